// File: rtl/router_ctrl.sv
// router_ctrl: 1x3 router packet controller (steering, parity, FIFO timeouts).
// Define ROUTER_LEN_CHECK_EN to also flag payload-length mismatches in err.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_en,
  output logic       busy,
  output logic [2:0] write_en,
  output logic       lfd_state,
  output logic [7:0] dout,
  output logic [2:0] vld_out,
  output logic [2:0] soft_rst,
  output logic       err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    CHECK_PARITY_ERROR
  } state_t;

  state_t state, state_nx;

  logic [1:0] addr;
  logic [7:0] hold;
  logic       hold_par;
  logic [7:0] calc_par;
  logic [7:0] rx_par;
  logic       resync;

`ifdef ROUTER_LEN_CHECK_EN
  logic [5:0] hdr_len;
  logic [5:0] len_cnt;
`endif

  // Pad to 4 entries so a 2-bit address never indexes out of range.
  logic [3:0] full_x, empty_x, srst_x;
  logic       cur_full, cur_empty, abort, hdr_ok;
  logic [2:0] sel;

  assign full_x    = {1'b0, fifo_full};
  assign empty_x   = {1'b0, fifo_empty};
  assign srst_x    = {1'b0, soft_rst};
  assign cur_full  = full_x[addr];
  assign cur_empty = empty_x[addr];
  assign abort     = (state != DECODE_ADDRESS) && srst_x[addr];
  assign hdr_ok    = pkt_valid && !resync && (data_in[1:0] != 2'd3);
  assign sel       = 3'b001 << addr;
  assign vld_out   = ~fifo_empty;

  for (genvar i = 0; i < 3; i++) begin : g_to
    logic [CW-1:0] cnt;
    assign soft_rst[i] = vld_out[i] && !read_en[i]
                      && (cnt == CW'(TIMEOUT));
    always_ff @(posedge clk) begin
      if (!rstn || !vld_out[i] || read_en[i] || soft_rst[i])
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= DECODE_ADDRESS;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    write_en  = '0;
    lfd_state = 1'b0;
    dout      = '0;
    unique case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok)
          state_nx = empty_x[data_in[1:0]] ? LOAD_FIRST_DATA
                                           : WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (cur_empty) state_nx = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        write_en  = sel;
        dout      = hold;
        state_nx  = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (cur_full) begin
          state_nx = FIFO_FULL_STATE;
        end else begin
          write_en = sel;
          dout     = data_in;
          if (!pkt_valid) state_nx = CHECK_PARITY_ERROR;
        end
      end
      FIFO_FULL_STATE: begin
        busy = 1'b1;
        if (!cur_full) state_nx = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        busy     = 1'b1;
        write_en = sel;
        dout     = hold;
        state_nx = hold_par ? CHECK_PARITY_ERROR : LOAD_DATA;
      end
      CHECK_PARITY_ERROR: begin
        busy     = 1'b1;
        state_nx = DECODE_ADDRESS;
      end
      default: state_nx = DECODE_ADDRESS;
    endcase
    if (abort) state_nx = DECODE_ADDRESS;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr     <= '0;
      hold     <= '0;
      hold_par <= 1'b0;
      calc_par <= '0;
      rx_par   <= '0;
      resync   <= 1'b0;
      err      <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
      hdr_len  <= '0;
      len_cnt  <= '0;
`endif
    end else if (abort) begin
      resync <= 1'b1;
    end else begin
      unique case (state)
        DECODE_ADDRESS: begin
          if (!pkt_valid) begin
            resync <= 1'b0;
          end else if (hdr_ok) begin
            addr <= data_in[1:0];
            hold <= data_in;
            err  <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
            hdr_len <= data_in[7:2];
`endif
          end
        end
        LOAD_FIRST_DATA: begin
          calc_par <= hold;
`ifdef ROUTER_LEN_CHECK_EN
          len_cnt  <= '0;
`endif
        end
        LOAD_DATA: begin
          if (cur_full) begin
            hold     <= data_in;
            hold_par <= !pkt_valid;
          end else if (pkt_valid) begin
            calc_par <= calc_par ^ data_in;
`ifdef ROUTER_LEN_CHECK_EN
            len_cnt  <= len_cnt + 6'd1;
`endif
          end else begin
            rx_par <= data_in;
          end
        end
        LOAD_AFTER_FULL: begin
          if (hold_par) begin
            rx_par <= hold;
          end else begin
            calc_par <= calc_par ^ hold;
`ifdef ROUTER_LEN_CHECK_EN
            len_cnt  <= len_cnt + 6'd1;
`endif
          end
        end
        CHECK_PARITY_ERROR: begin
`ifdef ROUTER_LEN_CHECK_EN
          err <= (calc_par != rx_par) || (len_cnt != hdr_len);
`else
          err <= (calc_par != rx_par);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed per-cycle vectors for router_ctrl.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_router_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_en;
  logic       busy;
  logic [2:0] write_en;
  logic       lfd_state;
  logic [7:0] dout;
  logic [2:0] vld_out;
  logic [2:0] soft_rst;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  router_ctrl #(.TIMEOUT(30)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_en(read_en),
    .busy(busy), .write_en(write_en), .lfd_state(lfd_state), .dout(dout),
    .vld_out(vld_out), .soft_rst(soft_rst), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0;
    pkt_valid = 1'b1;
    data_in = 8'h0D;
    fifo_full = '0;
    fifo_empty = 3'b111;
    read_en = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, lfd_state, write_en, dout, err} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_out: got %b/%b/%b/%h/%b want all zero",
               busy, lfd_state, write_en, dout, err);
    end
    n_cmp++;
    if (soft_rst !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_srst: got %b want 000", soft_rst);
    end
    @(negedge clk);
    fifo_empty = 3'b010;
    #1;
    n_cmp++;
    if (vld_out !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_vld: got %b want 101", vld_out);
    end
    @(negedge clk);
    fifo_empty = 3'b111;
    pkt_valid = 1'b0;
    data_in = 8'h00;
    rstn = 1'b1;
  endtask

  task automatic test_good_packet();
    logic [7:0] t_din [8] = '{8'h0D, 8'h11, 8'h11, 8'h22,
                              8'h33, 8'h0D, 8'h00, 8'h00};
    logic [2:0] t_we [8] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [7:0] t_do [8] = '{8'h00, 8'h0D, 8'h11, 8'h22,
                             8'h33, 8'h0D, 8'h00, 8'h00};
    logic [0:7] t_pv = 8'b11111000;
    logic [0:7] t_bz = 8'b01000010;
    logic [0:7] t_lf = 8'b01000000;
    logic [0:7] t_er = 8'b00000000;
    logic [13:0] exp;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], t_er[c]};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err} !== exp) begin
        n_bad++;
        $display("FAIL good_pkt c%0d: got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                 c, busy, lfd_state, write_en, dout, err,
                 exp[13], exp[12], exp[11:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_bad_parity();
    logic [7:0] t_din [13] = '{8'h0D, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00,
                               8'h00, 8'h06, 8'hAA, 8'hAA, 8'hAC, 8'h00,
                               8'h00};
    logic [2:0] t_we [13] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0,
                              3'd0, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0};
    logic [7:0] t_do [13] = '{8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h00,
                              8'h00, 8'h00, 8'h06, 8'hAA, 8'hAC, 8'h00,
                              8'h00};
    logic [0:12] t_pv = 13'b1111100111000;
    logic [0:12] t_bz = 13'b0100001010010;
    logic [0:12] t_lf = 13'b0100000010000;
    logic [0:12] t_er = 13'b0000000100000;
    logic [13:0] exp;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], t_er[c]};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err} !== exp) begin
        n_bad++;
        $display("FAIL bad_par c%0d: got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                 c, busy, lfd_state, write_en, dout, err,
                 exp[13], exp[12], exp[11:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] t_din [13] = '{8'h0D, 8'h11, 8'h11, 8'h22, 8'h33, 8'h33,
                               8'h33, 8'h33, 8'h33, 8'h33, 8'h0D, 8'h00,
                               8'h00};
    logic [2:0] t_we [13] = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [7:0] t_do [13] = '{8'h00, 8'h0D, 8'h11, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h22, 8'h33, 8'h0D, 8'h00,
                              8'h00};
    logic [0:12] t_pv = 13'b1111111111000;
    logic [0:12] t_fl = 13'b0001111000000;
    logic [0:12] t_bz = 13'b0100111110010;
    logic [0:12] t_lf = 13'b0100000000000;
    logic [13:0] exp;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      fifo_full = {1'b0, t_fl[c], 1'b0};
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], 1'b0};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err} !== exp) begin
        n_bad++;
        $display("FAIL full_stall c%0d: got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                 c, busy, lfd_state, write_en, dout, err,
                 exp[13], exp[12], exp[11:9], exp[8:1], exp[0]);
      end
    end
    fifo_full = '0;
  endtask

  task automatic test_wait_empty();
    logic [7:0] t_din [9] = '{8'h06, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                              8'hAA, 8'hAC, 8'h00, 8'h00};
    logic [2:0] t_we [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4,
                             3'd4, 3'd4, 3'd0, 3'd0};
    logic [7:0] t_do [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h06,
                             8'hAA, 8'hAC, 8'h00, 8'h00};
    logic [0:8] t_pv = 9'b111111000;
    logic [0:8] t_e2 = 9'b000111111;
    logic [0:8] t_bz = 9'b011110010;
    logic [0:8] t_lf = 9'b000010000;
    logic [16:0] exp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      fifo_empty = {t_e2[c], 2'b11};
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], 1'b0, !t_e2[c], 2'b00};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err, vld_out} !== exp) begin
        n_bad++;
        $display("FAIL wait_empty c%0d: got %b/%b/%b/%h/%b/%b want %b/%b/%b/%h/%b/%b",
                 c, busy, lfd_state, write_en, dout, err, vld_out,
                 exp[16], exp[15], exp[14:12], exp[11:4], exp[3], exp[2:0]);
      end
    end
    fifo_empty = 3'b111;
  endtask

  task automatic test_addr3();
    logic [7:0] t_din [9] = '{8'hFF, 8'hFF, 8'h00, 8'h05, 8'h77,
                              8'h77, 8'h72, 8'h00, 8'h00};
    logic [2:0] t_we [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2,
                             3'd2, 3'd2, 3'd0, 3'd0};
    logic [7:0] t_do [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
                             8'h77, 8'h72, 8'h00, 8'h00};
    logic [0:8] t_pv = 9'b110111000;
    logic [0:8] t_bz = 9'b000010010;
    logic [0:8] t_lf = 9'b000010000;
    logic [13:0] exp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], 1'b0};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err} !== exp) begin
        n_bad++;
        $display("FAIL addr3 c%0d: got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                 c, busy, lfd_state, write_en, dout, err,
                 exp[13], exp[12], exp[11:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [7:0] t_din [5] = '{8'h0D, 8'h11, 8'h11, 8'h00, 8'h00};
    logic [2:0] t_we [5] = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [7:0] t_do [5] = '{8'h00, 8'h0D, 8'h11, 8'h00, 8'h00};
    logic [0:4] t_pv = 5'b11100;
    logic [0:4] t_rs = 5'b11011;
    logic [0:4] t_bz = 5'b01000;
    logic [0:4] t_lf = 5'b01000;
    logic [13:0] exp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pkt_valid = t_pv[c];
      data_in = t_din[c];
      rstn = t_rs[c];
      #1;
      exp = {t_bz[c], t_lf[c], t_we[c], t_do[c], 1'b0};
      n_cmp++;
      if ({busy, lfd_state, write_en, dout, err} !== exp) begin
        n_bad++;
        $display("FAIL rst_mid c%0d: got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                 c, busy, lfd_state, write_en, dout, err,
                 exp[13], exp[12], exp[11:9], exp[8:1], exp[0]);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    pkt_valid = 1'b0;
    read_en = '0;
    fifo_empty = 3'b110;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (soft_rst !== ((k == 30) ? 3'b001 : 3'b000)) begin
        n_bad++;
        $display("FAIL timeout_pulse k%0d: got %b want %b", k, soft_rst,
                 (k == 30) ? 3'b001 : 3'b000);
      end
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      read_en = (k == 29) ? 3'b001 : 3'b000;
      #1;
      n_cmp++;
      if (soft_rst !== 3'b000) begin
        n_bad++;
        $display("FAIL timeout_read29 k%0d: got %b want 000", k, soft_rst);
      end
    end
    @(negedge clk);
    read_en = '0;
    fifo_empty = 3'b111;
    @(negedge clk);
    fifo_empty = 3'b110;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      read_en = (k == 30) ? 3'b001 : 3'b000;
      #1;
      n_cmp++;
      if (soft_rst !== 3'b000) begin
        n_bad++;
        $display("FAIL timeout_same k%0d: got %b want 000", k, soft_rst);
      end
    end
    @(negedge clk);
    read_en = '0;
    fifo_empty = 3'b111;
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_full_stall();
    test_wait_empty();
    test_addr3();
    test_reset_midpacket();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet-level controller for the 1x3 router. Sits between the input port and the three output FIFOs. Decodes each header byte and steers header, payload and parity bytes into the addressed FIFO with `write_en`/`lfd_state`. It also throttles the source with `busy` around full/non-empty FIFOs, checks packet parity, and generates per-port `vld_out` plus timeout-driven `soft_rst` for unread FIFOs.

## Interface
- `TIMEOUT`, 30: consecutive cycles a FIFO may hold data with no read before its `soft_rst` pulses; counter width is clog2(TIMEOUT+1).
- `clk` in 1: clock; all state updates on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `pkt_valid` in 1: high during header and payload bytes, low on the parity byte.
- `data_in` in 8: source byte. Header format: [7:2] payload length (1..63), [1:0] destination (0..2; 3 invalid).
- `fifo_full` in 3: per-FIFO full flags.
- `fifo_empty` in 3: per-FIFO empty flags.
- `read_en` in 3: downstream read strobes per port.
- `busy` out 1: source must hold `data_in`/`pkt_valid` stable while high.
- `write_en` out 3: one-hot write strobe to FIFO[addr]; combinational from state and flags.
- `lfd_state` out 1: high in the cycle the header is written.
- `dout` out 8: byte to FIFOs; 0 whenever `write_en`==0.
- `vld_out` out 3: `~fifo_empty`, combinational.
- `soft_rst` out 3: one-cycle timeout pulse per FIFO.
- `err` out 1: registered parity (and optional length) error.

## Operation
- Registers: `addr[1:0]`, `hold[7:0]`, `hold_par` (hold holds the parity byte), `calc_par[7:0]`, `rx_par[7:0]`, `resync`, three timeout counters.
- States:
  - DECODE_ADDRESS (reset state)
  - WAIT_TILL_EMPTY
  - LOAD_FIRST_DATA
  - LOAD_DATA
  - FIFO_FULL_STATE
  - LOAD_AFTER_FULL
  - CHECK_PARITY_ERROR
- DECODE_ADDRESS: `busy`=0.
  - If `pkt_valid` && !`resync` && `data_in[1:0]`!=3: latch addr and hold=header. Go to LOAD_FIRST_DATA if `fifo_empty[addr]`, else WAIT_TILL_EMPTY.
  - Address 3: byte dropped; stay in DECODE_ADDRESS.
  - `resync` clears when `pkt_valid`=0.
- WAIT_TILL_EMPTY: `busy`=1; go to LOAD_FIRST_DATA when `fifo_empty[addr]`.
- LOAD_FIRST_DATA: `busy`=1, `lfd_state`=1, `write_en[addr]`=1, `dout`=hold. Then calc_par<=hold and go to LOAD_DATA.
- LOAD_DATA: `busy`=0; byte on `data_in` is accepted every cycle.
  - If `fifo_full[addr]`: hold<=data_in, hold_par<=!pkt_valid, no write, go to FIFO_FULL_STATE.
  - Else if `pkt_valid`: `write_en[addr]`=1, `dout`=data_in, calc_par^=data_in.
  - Else (parity byte): write it, rx_par<=data_in, go to CHECK_PARITY_ERROR.
- FIFO_FULL_STATE: `busy`=1; go to LOAD_AFTER_FULL when !`fifo_full[addr]`.
- LOAD_AFTER_FULL: `busy`=1, `write_en[addr]`=1, `dout`=hold.
  - Payload byte: calc_par^=hold, go to LOAD_DATA.
  - Parity byte: rx_par<=hold, go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: `busy`=1; err<=(calc_par!=rx_par); go to DECODE_ADDRESS.
- `err` clears when the next valid header is accepted.
- Timeout, per port i:
  - Counter increments while `vld_out[i]` && !`read_en[i]`; clears on `read_en[i]` or when `vld_out[i]`=0.
  - When the counter reaches TIMEOUT: `soft_rst[i]`=1 for one cycle, counter clears.
- Abort: `soft_rst[addr]` in any state other than DECODE_ADDRESS sends the FSM to DECODE_ADDRESS next cycle with `resync`=1. The rest of the packet is ignored until `pkt_valid` goes low. `err` is unchanged.

## Timing
- Header accepted at edge N, target FIFO empty: header written at edge N+1. First payload byte accepted at edge N+2.
- Each payload byte: one cycle if the FIFO is not full.
- Full stall: the byte is captured at the full edge. It is rewritten one cycle after `fifo_full` drops, and LOAD_DATA resumes the following cycle.
- `err` valid one cycle after the parity byte is written. A new header can be accepted two cycles after the parity byte.
- Reset values: `busy`=0, `write_en`=0, `lfd_state`=0, `dout`=0, `soft_rst`=0, `err`=0, counters=0, `resync`=0, state=DECODE_ADDRESS.
- `rstn` low mid-packet abandons the packet immediately.
- `soft_rst` and `read_en` in the same cycle: `read_en` clears the counter first, so no pulse.

## Configuration
- `ROUTER_LEN_CHECK_EN` defined:
  - A 6-bit counter counts payload bytes written.
  - In CHECK_PARITY_ERROR: err<=(parity mismatch) || (count != header[7:2]).
- Not defined: no counter; `err` reflects parity only.

## Test plan
- Header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D -> FIFO1 gets 5 writes, `lfd_state` only on the header, `err`=0, `busy` high for exactly 2 cycles.
- Same packet with parity 0x00 -> all 5 bytes written, `err`=1 one cycle after the parity write; next header clears it.
- `fifo_full[1]` raised before the 2nd payload byte for 4 cycles -> `busy`=1, no write while full, byte 0x22 written once after release, parity still correct.
- Header addr 2 while `fifo_empty[2]`=0 -> WAIT_TILL_EMPTY with `busy`=1 until empty, then header written.
- `vld_out[0]`=1 with no `read_en` for 30 cycles -> `soft_rst[0]` one-cycle pulse at cycle 30. A read at cycle 29 -> no pulse.
- Header byte 0xFF (addr 3) -> no `write_en`, `busy`=0, FSM stays in DECODE_ADDRESS.
